uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  UART transmit stage that produces the serial stream the apb_uart_rx block consumes.
//  Byte-wide valid/ready input, buffered in a small FIFO.
//  Each entry is serialised as start(0) + data_size data bits (LSB first) + stop(1).
//  Uses the same 14-bit bit_period / 4-bit data_size configuration encoding as the receiver.
// PARAMETERS
//  FIFO_DEPTH  4  entries in the input buffer; power of two, >= 2
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst         in   1   synchronous, active-high reset
//  bit_period  in   14  clocks per serial bit; 0 = transmitter halted
//  data_size   in   4   data bits per frame, legal 5..8
//  tx_data     in   8   byte to send; only bits [data_size-1:0] are transmitted
//  tx_valid    in   1   producer offers tx_data
//  tx_ready    out  1   FIFO can accept; equals !full, registered
//  serial_out  out  1   UART line, idle high, registered
//  tx_busy     out  1   high while the FSM is not IDLE
//  frame_done  out  1   one-cycle pulse on the last clock of each stop bit
// BEHAVIOUR
//  Reset:
//   - Outputs: serial_out=1, tx_ready=1, tx_busy=0, frame_done=0.
//   - FIFO is emptied and the FSM goes to IDLE.
//   - Applies mid-frame too: the frame is aborted and the line returns high on the next edge.
//  Push handshake:
//   - An entry is pushed on an edge where tx_valid && tx_ready.
//   - tx_valid while !tx_ready is ignored; tx_data is not captured.
//  Pop and push together:
//   - Allowed in the same cycle; count is unchanged.
//   - When full, tx_ready is 0, so there is no push even if a pop occurs that cycle.
//  FSM states: IDLE, START, DATA, STOP.
//  IDLE -> START when the FIFO is non-empty and bit_period != 0.
//   - On that edge: pop the head entry into shift_reg.
//   - Latch bit_period into per_q and data_size into size_q; both are frozen for the whole frame.
//   - The same edge drives serial_out=0.
//  Latency: a push into an empty FIFO while IDLE -> serial_out falls on the next rising edge.
//  Bit timing:
//   - A 14-bit counter counts 1..per_q.
//   - Each state holds for exactly per_q clocks; at count==per_q the counter wraps to 1 and the state or bit advances.
//  START -> DATA: serial_out = shift_reg[0].
//  DATA:
//   - On each bit end, shift right and increment bit_idx.
//   - After bit_idx == size_q-1 completes -> STOP with serial_out=1.
//  STOP end:
//   - frame_done=1 for that final cycle.
//   - If the FIFO is non-empty and bit_period != 0: go directly to START (pop, relatch, serial_out=0). No idle gap between frames.
//   - Otherwise go to IDLE.
//  Frame length is exactly (size_q+2)*per_q clocks.
//  data_size outside 5..8 (0-4, 9-15) is latched as 8.
//  bit_period = 0:
//   - No new frame starts.
//   - A frame already in flight completes using per_q; live config changes mid-frame have no effect.
//  bit_period = 1: legal; each bit is one clock.
//  tx_busy = (state != IDLE).
// STRUCTURE
//  uart_pkg (shared with the rx side):
//   - typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t.
//   - localparams BIT_PERIOD_W=14, DATA_SIZE_W=4, MIN_DATA_SIZE=5, MAX_DATA_SIZE=8.
//  Sub-module tx_fifo #(DEPTH, WIDTH=8):
//   - Synchronous FIFO: wr_en, rd_en, full, empty, rdata.
//   - Head data is visible combinationally (first-word fall-through).
//  Top level: FSM, bit counter, bit_idx, shift_reg, config latches.
// TESTING
//  1. Reset, then idle 20 clocks -> serial_out=1, tx_ready=1, tx_busy=0 throughout.
//  2. period=10, size=5, push 8'h15 -> serial_out falls 1 clk after push.
//     Line = 0,1,0,1,0,1,1 with each bit 10 clk; frame_done pulses at clk 70; tx_busy low after.
//  3. period=4, size=8, push A5,3C,FF,00,81 back-to-back:
//     - tx_ready drops after the 4th entry is buffered (1st already popped, so 5th is accepted).
//     - All 5 frames are contiguous, 40 clk each.
//     - Serial stream decodes to A5,3C,FF,00,81.
//  4. Start an 8-bit frame with period=10; write period=3, size=5 mid-frame:
//     - Current frame keeps 10 clk/bit and 8 bits.
//     - Next frame uses 3 clk/bit, 5 bits.
//  5. period=0, push 8'h55 -> no transmission, tx_busy=0; set period=2 -> frame starts next edge.
//  6. Assert rst during DATA of frame 1 with 2 entries queued:
//     - Next edge: serial_out=1, FIFO empty, IDLE, tx_ready=1.
//     - No further frames are sent.
//  Loopback: serial_out into apb_uart_rx with the same config -> APB read of RX data returns each sent byte.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types, widths and frame-size helper (tx and rx).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int BIT_PERIOD_W = 14;
    localparam int DATA_SIZE_W  = 4;

    localparam logic [DATA_SIZE_W-1:0] MIN_DATA_SIZE = 4'd5;
    localparam logic [DATA_SIZE_W-1:0] MAX_DATA_SIZE = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Out-of-range size codes fall back to a full byte frame.
    function automatic logic [DATA_SIZE_W-1:0] legal_size(input logic [DATA_SIZE_W-1:0] size);
        if (size < MIN_DATA_SIZE || size > MAX_DATA_SIZE) begin
            return MAX_DATA_SIZE;
        end
        return size;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tx_fifo
//  Description : Synchronous first-word fall-through FIFO with registered full.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_full;
    logic [c_PTR_W:0]   w_count_nxt;
    logic               w_wr;
    logic               w_rd;

    assign w_wr  = wr_en && !r_full;
    assign w_rd  = rd_en && (r_count != '0);
    assign rdata = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = (r_count == '0);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_nxt = r_count + (c_PTR_W+1)'(1);
            2'b01:   w_count_nxt = r_count - (c_PTR_W+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Full is registered from the next occupancy so the ready output has no input path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (c_PTR_W+1)'(DEPTH));
        end
    end

endmodule : tx_fifo
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_serializer
//  Description : Buffered UART transmitter, start + 5..8 data bits LSB first + stop.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BIT_PERIOD_W-1:0] bit_period,
    input  logic [DATA_SIZE_W-1:0]  data_size,
    input  logic [7:0]              tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    serial_out,
    output logic                    tx_busy,
    output logic                    frame_done
);

    tx_state_t               r_state, w_state_nxt;
    logic [BIT_PERIOD_W-1:0] r_cnt, w_cnt_nxt;
    logic [BIT_PERIOD_W-1:0] r_per, w_per_nxt;
    logic [DATA_SIZE_W-1:0]  r_size, w_size_nxt;
    logic [2:0]              r_bit_idx, w_bit_idx_nxt;
    logic [7:0]              r_shift, w_shift_nxt;
    logic                    r_serial, w_serial_nxt;

    logic       w_full;
    logic       w_empty;
    logic [7:0] w_head;
    logic       w_pop;
    logic       w_load;
    logic       w_bit_end;
    logic       w_can_start;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (tx_valid),
        .wdata (tx_data),
        .rd_en (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign tx_ready    = !w_full;
    assign serial_out  = r_serial;
    assign tx_busy     = (r_state != IDLE);
    assign w_bit_end   = (r_cnt == r_per);
    assign frame_done  = (r_state == STOP) && w_bit_end;
    assign w_can_start = !w_empty && (bit_period != '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = w_bit_end ? BIT_PERIOD_W'(1) : r_cnt + BIT_PERIOD_W'(1);
        w_per_nxt     = r_per;
        w_size_nxt    = r_size;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_serial_nxt  = r_serial;
        w_load        = 1'b0;
        w_pop         = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = r_cnt;
                w_load    = w_can_start;
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt   = DATA;
                    w_bit_idx_nxt = 3'd0;
                    w_serial_nxt  = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if ({1'b0, r_bit_idx} == r_size - 4'd1) begin
                        w_state_nxt  = STOP;
                        w_serial_nxt = 1'b1;
                    end else begin
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_serial_nxt  = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                    w_load      = w_can_start;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Frame launch: config is frozen here for the whole frame, back-to-back from STOP.
        if (w_load) begin
            w_pop        = 1'b1;
            w_state_nxt  = START;
            w_shift_nxt  = w_head;
            w_per_nxt    = bit_period;
            w_size_nxt   = legal_size(data_size);
            w_cnt_nxt    = BIT_PERIOD_W'(1);
            w_serial_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= BIT_PERIOD_W'(1);
            r_per     <= BIT_PERIOD_W'(1);
            r_size    <= MAX_DATA_SIZE;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_serial  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_per     <= w_per_nxt;
            r_size    <= w_size_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_serial  <= w_serial_nxt;
        end
    end

endmodule : uart_tx_serializer
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_serializer
//  Description : Scoreboard bench: queued expected frames checked against the line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

    logic        tb_clk = 1'b0;
    logic        rst;
    logic [13:0] bit_period;
    logic [3:0]  data_size;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        serial_out;
    logic        tx_busy;
    logic        frame_done;

    always #5 tb_clk = ~tb_clk;

    uart_tx_serializer #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (tb_clk),
        .rst        (rst),
        .bit_period (bit_period),
        .data_size  (data_size),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [7:0] data;
        int         size;
        int         per;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   starts[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   frames_seen = 0;
    int   push_cyc = 0;
    bit   mon_active = 1'b0;
    int   b, c, terr, ferr;
    logic [7:0] acc;
    logic want;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Line monitor: decodes each frame cycle by cycle against the oldest expected entry.
    always @(negedge tb_clk) begin
        cyc++;
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && serial_out == 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    cur = '{8'h00, 8, 1};
                end else begin
                    cur = exp_q.pop_front();
                end
                mon_active = 1'b1;
                b = 0; c = 0; terr = 0; ferr = 0; acc = 8'h00;
                starts.push_back(cyc);
            end
            if (mon_active) begin
                if (b == 0) begin
                    want = 1'b0;
                end else if (b <= cur.size) begin
                    if (c == 0) acc[b-1] = serial_out;
                    want = acc[b-1];
                end else begin
                    want = 1'b1;
                end
                if (serial_out !== want || tx_busy !== 1'b1) terr++;
                if (frame_done !== (b == cur.size + 1 && c == cur.per - 1)) ferr++;
                if (c == cur.per - 1) begin
                    c = 0;
                    b++;
                end else begin
                    c++;
                end
                if (b == cur.size + 2) begin
                    check("frame_data", 32'(acc), 32'(cur.data));
                    check("frame_timing", 32'(terr), 32'd0);
                    check("frame_done_pulse", 32'(ferr), 32'd0);
                    frames_seen++;
                    mon_active = 1'b0;
                end
            end
        end
    end

    // Entered at a negedge; returns at a negedge with the entry accepted and queued.
    task automatic push(input logic [7:0] d, input int sz, input int per);
        int n = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        while (!tx_ready && n < 500) begin
            @(negedge tb_clk);
            n++;
        end
        check("push_accepted", 32'(tx_ready), 32'd1);
        @(posedge tb_clk);
        push_cyc = cyc;
        exp_q.push_back('{d & (8'hFF >> (8 - sz)), sz, per});
        @(negedge tb_clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames_seen < n && k < budget) begin
            @(negedge tb_clk);
            k++;
        end
        check("wait_frames", 32'(frames_seen >= n), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, s0, bad;
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        bit_period = 14'd0; data_size = 4'd8;
        repeat (3) @(negedge tb_clk);
        check("rst_serial", 32'(serial_out), 32'd1);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        rst = 1'b0;

        // Idle after reset.
        bad = 0;
        repeat (20) begin
            @(negedge tb_clk);
            if (serial_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        check("idle_20", 32'(bad), 32'd0);

        // Single 5-bit frame, period 10.
        bit_period = 14'd10; data_size = 4'd5;
        base = frames_seen;
        push(8'h15, 5, 10);
        wait_frames(base + 1, 200);
        check("first_latency", 32'(starts[starts.size()-1]), 32'(push_cyc + 2));
        @(negedge tb_clk);
        check("busy_after", 32'(tx_busy), 32'd0);
        check("line_idle_after", 32'(serial_out), 32'd1);

        // Five back-to-back bytes, period 4; FIFO fills on the fifth.
        bit_period = 14'd4; data_size = 4'd8;
        base = frames_seen; s0 = starts.size();
        push(8'hA5, 8, 4);
        push(8'h3C, 8, 4);
        push(8'hFF, 8, 4);
        push(8'h00, 8, 4);
        check("ready_before_5th", 32'(tx_ready), 32'd1);
        push(8'h81, 8, 4);
        check("ready_full", 32'(tx_ready), 32'd0);
        tx_valid = 1'b1; tx_data = 8'hEE;
        @(negedge tb_clk);
        tx_valid = 1'b0;
        wait_frames(base + 5, 400);
        for (int i = 0; i < 4; i++) begin
            check("contiguous_40", 32'(starts[s0+i+1] - starts[s0+i]), 32'd40);
        end

        // Config changed mid-frame applies only to the following frame.
        bit_period = 14'd10; data_size = 4'd8;
        base = frames_seen; s0 = starts.size();
        push(8'hC3, 8, 10);
        repeat (25) @(negedge tb_clk);
        bit_period = 14'd3; data_size = 4'd5;
        push(8'h5A, 5, 3);
        wait_frames(base + 2, 300);
        check("midframe_len", 32'(starts[s0+1] - starts[s0]), 32'd100);

        // Halted transmitter, then release; illegal size code 12 sends 8 bits.
        bit_period = 14'd0; data_size = 4'd12;
        base = frames_seen;
        push(8'h55, 8, 2);
        repeat (20) @(negedge tb_clk);
        check("halt_busy", 32'(tx_busy), 32'd0);
        check("halt_line", 32'(serial_out), 32'd1);
        check("halt_frames", 32'(frames_seen), 32'(base));
        bit_period = 14'd2;
        @(posedge tb_clk);
        s0 = cyc;
        wait_frames(base + 1, 100);
        check("release_latency", 32'(starts[starts.size()-1]), 32'(s0 + 1));

        // One clock per bit.
        bit_period = 14'd1; data_size = 4'd6;
        base = frames_seen; s0 = starts.size();
        push(8'h2A, 6, 1);
        push(8'hD5, 6, 1);
        wait_frames(base + 2, 100);
        check("period1_len", 32'(starts[s0+1] - starts[s0]), 32'd8);

        // Reset in the middle of a data bit with two entries queued.
        bit_period = 14'd10; data_size = 4'd8;
        push(8'h96, 8, 10);
        push(8'h11, 8, 10);
        push(8'h22, 8, 10);
        repeat (20) @(negedge tb_clk);
        check("pre_rst_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge tb_clk);
        check("midrst_serial", 32'(serial_out), 32'd1);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        rst = 1'b0;
        base = frames_seen;
        bad = 0;
        repeat (100) begin
            @(negedge tb_clk);
            if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) bad++;
        end
        check("post_rst_quiet", 32'(bad), 32'd0);
        check("post_rst_frames", 32'(frames_seen), 32'(base));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_tx_serializer
`default_nettype wire
